// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register-write target.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;

  // Bit counter saturates here so long frames stay distinguishable from 16-bit frames.
  localparam logic [4:0] BIT_CNT_SAT = 5'd17;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StCommit = 2'd2
  } state_e;

endpackage

// File: rtl/spi_reg_peripheral_sync_ff.sv
// Parameterised-depth synchroniser flop chain with a configurable reset value.
module sync_ff #(
  parameter int unsigned Depth    = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [Depth-1:0] chain_q;

  // Shift the asynchronous input through the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {Depth{ResetVal}};
    end else begin
      chain_q <= {chain_q[Depth-2:0], d};
    end
  end

  assign q = chain_q[Depth-1];

endmodule

// File: rtl/spi_reg_peripheral.sv
// Write-only SPI (mode 0, MSB first) target holding the five PWM control registers.
import spi_reg_pkg::*;

module spi_reg_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  logic sclk_s, copi_s, ncs_s;
  logic sclk_hist_q, ncs_hist_q;
  logic sclk_rise, ncs_rise, ncs_fall;

  state_e state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [7:0]            regs_q [5];
  logic [7:0]            regs_d [5];

  logic       commit_en;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;

  sync_ff #(.Depth(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sclk),
    .q     (sclk_s)
  );

  sync_ff #(.Depth(SYNC_STAGES), .ResetVal(1'b0)) u_sync_copi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (copi),
    .q     (copi_s)
  );

  // ncs idles high, so its chain resets high to avoid a fake rising edge after reset.
  sync_ff #(.Depth(SYNC_STAGES), .ResetVal(1'b1)) u_sync_ncs (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ncs),
    .q     (ncs_s)
  );

  // History flops for edge detection on the synchronised sclk and ncs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_hist_q <= 1'b0;
      ncs_hist_q  <= 1'b1;
    end else begin
      sclk_hist_q <= sclk_s;
      ncs_hist_q  <= ncs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign ncs_rise  = ncs_s & ~ncs_hist_q;
  assign ncs_fall  = ~ncs_s & ncs_hist_q;

  assign frame_addr = shift_q[14:8];
  assign frame_data = shift_q[7:0];

  // The write is issued on the ncs rising edge so the register shows the new value
  // while the FSM sits in Commit.
  assign commit_en = (state_q == StShift) && ncs_rise &&
                     (cnt_q == 5'(FRAME_BITS)) && shift_q[15] && (frame_addr <= MAX_ADDR);

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (ncs_fall) state_d = StShift;
      StShift:  if (ncs_rise) state_d = StCommit;
      StCommit: state_d = ncs_fall ? StShift : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Shift register and saturating bit counter; ncs rise wins over a coincident sclk rise.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (ncs_fall) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if ((state_q == StShift) && !ncs_rise && sclk_rise) begin
      shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
      if (cnt_q < BIT_CNT_SAT) begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  // Register file update: at most one register per accepted frame.
  always_comb begin
    regs_d = regs_q;
    if (commit_en) begin
      case (frame_addr)
        ADDR_EN_OUT_LO: regs_d[0] = frame_data;
        ADDR_EN_OUT_HI: regs_d[1] = frame_data;
        ADDR_EN_PWM_LO: regs_d[2] = frame_data;
        ADDR_EN_PWM_HI: regs_d[3] = frame_data;
        ADDR_DUTY:      regs_d[4] = frame_data;
        default:        ;
      endcase
    end
  end

  // State, shifter and register file storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 5; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 5; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: doc/spi_reg_peripheral.md
# spi_reg_peripheral

Write-only SPI target (mode 0, MSB first) that receives 16-bit register-write frames from an external controller and holds the five PWM control registers. The pwm_peripheral consumes these registers. All SPI inputs are asynchronous to `clk`. They are synchronised and edge-detected internally, so the whole block runs on the single system clock.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth for `sclk`, `copi` and `ncs` (minimum 2).
- `MAX_ADDR`, default 7'h04: highest valid register address.

Ports:
- `clk`  in  1: system clock. One clock domain only.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `sclk`  in  1: SPI clock, asynchronous. Idle low.
- `copi`  in  1: SPI controller-out data, asynchronous.
- `ncs`  in  1: SPI chip select, asynchronous, active-low.
- `en_reg_out_7_0`  out  8: output-enable bits 7:0 (address 0x00).
- `en_reg_out_15_8`  out  8: output-enable bits 15:8 (address 0x01).
- `en_reg_pwm_7_0`  out  8: PWM-enable bits 7:0 (address 0x02).
- `en_reg_pwm_15_8`  out  8: PWM-enable bits 15:8 (address 0x03).
- `pwm_duty_cycle`  out  8: shared duty cycle, 0x00 = 0 % and 0xFF = 100 % (address 0x04).

## Operation
- Frame format, MSB first: bit15 = R/W (1 = write), bits14:8 = address[6:0], bits7:0 = data.
- Synchroniser: each input passes through `SYNC_STAGES` flops, then one extra history flop on `sclk` and `ncs` for edge detection.
- States:
  - IDLE: synchronised `ncs` is high.
  - SHIFT: `ncs` is low. Each synchronised `sclk` rising edge shifts synchronised `copi` into a 16-bit shift register (LSB entry) and increments a 5-bit bit counter. The counter saturates at 17 (overflow marker).
  - COMMIT: entered on the synchronised `ncs` rising edge. Lasts one cycle, then returns to IDLE.
- A synchronised `ncs` falling edge clears the shift register and the bit counter, from any state.
- Commit rule, in COMMIT: write data into the addressed register only if all three hold:
  - bit count is exactly 16;
  - R/W = 1;
  - address ≤ `MAX_ADDR`.
- Any other frame is discarded silently, with no register change. This covers short frames, long frames, reads and out-of-range addresses.
- `sclk` edges while `ncs` is high are ignored. Falling `sclk` edges are ignored.
- Registers hold their value indefinitely. There is no readback path; `cipo` is not implemented.
- At most one register is written per frame. The other four are unchanged.

## Timing
- Reset: all five outputs = 0x00. Shift register, bit counter, synchroniser and history flops are all 0. `ncs` history flops reset to 1, so the first deasserted `ncs` after reset does not produce a spurious edge. State = IDLE.
- Reset mid-frame: the frame is lost. After `rst_n` releases, the next `ncs` falling edge must be seen before any bits are accepted.
- Commit latency (`SYNC_STAGES` = 2): if `ncs` high is first captured at clk edge N, the target register shows the new value after edge N+2.
- SCLK constraint: high and low phases ≥ 3 `clk` periods each. Setup of `copi` to `sclk` rise ≥ 1 `clk` period. `ncs` low to first `sclk` rise ≥ 3 `clk` periods. Last `sclk` fall to `ncs` rise ≥ 3 `clk` periods.
- `ncs` high time between frames ≥ 4 `clk` periods.
- Simultaneous events: the `ncs` rising edge is evaluated before any `sclk` rising edge in the same cycle. A coincident `sclk` edge is not shifted in.

## Structure
- Shared package `spi_reg_pkg` holds:
  - `FRAME_BITS` = 16;
  - address constants `ADDR_EN_OUT_LO` = 0x00, `ADDR_EN_OUT_HI` = 0x01, `ADDR_EN_PWM_LO` = 0x02, `ADDR_EN_PWM_HI` = 0x03, `ADDR_DUTY` = 0x04;
  - the state enum (IDLE, SHIFT, COMMIT).
- One sub-module, `sync_ff`: parameterised-depth flop chain with a reset value, instantiated once per SPI input.
- Register file and frame decode stay in the top of this block.

## Test plan
- Reset check: assert `rst_n` = 0 mid-frame, release, then idle 10 cycles. All outputs = 0x00, and no write occurs when the partial frame's `ncs` rises.
- Single valid write: frame 0x80F0 (write, addr 0x00, data 0xF0). `en_reg_out_7_0` = 0xF0 after `ncs` rise plus 3 `clk`; the other four registers stay 0x00.
- Full register sweep: write 0x81CC, 0x8255, 0x83AA, 0x8480 in order. Outputs 15_8 = 0xCC, pwm_7_0 = 0x55, pwm_15_8 = 0xAA, duty = 0x80; `en_reg_out_7_0` is unchanged.
- Rejected frames, each sent with no change expected on any output:
  - read 0x00FF;
  - out-of-range 0x8511;
  - 15-bit frame;
  - 17-bit frame.
- Back-to-back frames at the minimum `ncs` gap (4 cycles) with `sclk` phases at 3 cycles: both writes land, and the second overwrites the first when both target address 0x04.
- Noise: toggle `sclk` while `ncs` is high, then send 0x8233. `en_reg_pwm_7_0` = 0x33, with no bit misalignment.
